trace_capture_unit: RTL and testbench

//  Synthesisable commit-trace capture for the pipelined cpu. Samples WB-stage reg writes and MEM-stage

---
 rtl/trace_capture_unit.sv | 194 +++++++++++++++++++
 tb/tb_trace_capture_unit.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/trace_capture_unit.sv
// trace_capture_unit: commit-trace capture for the pipelined cpu.
// Samples WB register writes and MEM loads/stores while running, stamps them
// with the run-cycle count and queues them in a FIFO drained over a
// valid/ready debug port. Also keeps cycle/instruction counters, halt
// detection and a cycle watchdog.
module trace_capture_unit #(
  parameter int DATA_W     = 16,
  parameter int ADDR_W     = 16,
  parameter int REG_W      = 4,
  parameter int DEPTH      = 16,
  parameter int CYCLE_W    = 32,
  parameter int MAX_CYCLES = 100000,
  parameter int DROP_W     = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               reg_wr,
  input  logic [REG_W-1:0]   wr_reg,
  input  logic [DATA_W-1:0]  wr_data,
  input  logic               mem_rd,
  input  logic               mem_wr,
  input  logic [ADDR_W-1:0]  mem_addr,
  input  logic [DATA_W-1:0]  mem_wdata,
  input  logic [DATA_W-1:0]  mem_rdata,
  input  logic               hlt,
  output logic               rec_valid,
  input  logic               rec_ready,
  output logic [1:0]         rec_kind,
  output logic [ADDR_W-1:0]  rec_addr,
  output logic [DATA_W-1:0]  rec_data,
  output logic [CYCLE_W-1:0] rec_cycle,
  output logic [1:0]         state,
  output logic [CYCLE_W-1:0] cycle_count,
  output logic [CYCLE_W-1:0] inst_count,
  output logic [DROP_W-1:0]  drop_count,
  output logic               overflow,
  output logic               done
);

  localparam int PTR_W = $clog2(DEPTH);

  localparam logic [1:0] KIND_REG   = 2'b00;
  localparam logic [1:0] KIND_LOAD  = 2'b01;
  localparam logic [1:0] KIND_STORE = 2'b10;

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    RUN     = 2'b01,
    HALTED  = 2'b10,
    TIMEOUT = 2'b11
  } stateT;

  typedef struct packed {
    logic [1:0]         kind;
    logic [ADDR_W-1:0]  addr;
    logic [DATA_W-1:0]  data;
    logic [CYCLE_W-1:0] stamp;
  } recordT;

  stateT            stateQ, stateNext;
  logic             capture;

  recordT           fifoMem [DEPTH];
  logic [PTR_W-1:0] wrPtr, rdPtr;
  logic [PTR_W:0]   occupancy;
  recordT           headRec;

  logic             pop, regPush, memPush;
  logic [1:0]       wantCount, pushCount, dropNow;
  logic [PTR_W+1:0] freeSlots;
  logic [CYCLE_W-1:0] stamp;
  recordT           regRec, memRec, firstRec;
  logic [DROP_W:0]  dropSum;

  // Next state and capture enable; start restarts from any state.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so no path leaves it unassigned and no latch is inferred.
    stateNext = stateQ;
    capture   = 1'b0;
    if (start) begin
      stateNext = RUN;
    end else begin
      case (stateQ)
        RUN: begin
          if (cycle_count == CYCLE_W'(MAX_CYCLES)) begin
            stateNext = TIMEOUT;
          end else begin
            capture = 1'b1;
            if (hlt) stateNext = HALTED;
          end
        end
        default: stateNext = stateQ;
      endcase
    end
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (rst) stateQ <= IDLE;
    else     stateQ <= stateNext;
  end

  // Build this cycle's records and work out how many fit in the FIFO.
  always_comb begin
    stamp     = cycle_count + CYCLE_W'(1);
    regPush   = capture & reg_wr;
    memPush   = capture & (mem_wr | mem_rd);

    regRec.kind  = KIND_REG;
    regRec.addr  = ADDR_W'(wr_reg);
    regRec.data  = wr_data;
    regRec.stamp = stamp;

    memRec.kind  = mem_wr ? KIND_STORE : KIND_LOAD;
    memRec.addr  = mem_addr;
    memRec.data  = mem_wr ? mem_wdata : mem_rdata;
    memRec.stamp = stamp;

    firstRec  = regPush ? regRec : memRec;

    wantCount = {1'b0, regPush} + {1'b0, memPush};
    // A pop this cycle frees its slot for a same-cycle push.
    freeSlots = (PTR_W+2)'(DEPTH) - (PTR_W+2)'(occupancy) + (PTR_W+2)'(pop);
    // Keep records in push order; anything past the free slots is dropped,
    // so a MEM record is always lost before a REG record.
    if ((PTR_W+2)'(wantCount) <= freeSlots) pushCount = wantCount;
    else                                    pushCount = freeSlots[1:0];
    dropNow   = wantCount - pushCount;
    dropSum   = {1'b0, drop_count} + (DROP_W+1)'(dropNow);
  end

  // FIFO pointers and occupancy; start flushes the queue.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wrPtr     <= '0;
      rdPtr     <= '0;
      occupancy <= '0;
    end else if (start) begin
      wrPtr     <= '0;
      rdPtr     <= '0;
      occupancy <= '0;
    end else begin
      wrPtr     <= wrPtr + PTR_W'(pushCount);
      if (pop) rdPtr <= rdPtr + PTR_W'(1);
      occupancy <= occupancy + (PTR_W+1)'(pushCount) - (PTR_W+1)'(pop);
    end
  end

  // FIFO storage writes: first record at wrPtr, second (always MEM) after it.
  always_ff @(posedge clk) begin
    // NOTE: storage has no reset; the pointers and occupancy define which entries are live.
    if (pushCount != 2'd0) fifoMem[wrPtr] <= firstRec;
    if (pushCount == 2'd2) fifoMem[wrPtr + PTR_W'(1)] <= memRec;
  end

  // Run counters, dropped-record counter and sticky overflow.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cycle_count <= '0;
      inst_count  <= '0;
      drop_count  <= '0;
      overflow    <= 1'b0;
    end else if (start) begin
      cycle_count <= '0;
      inst_count  <= '0;
      drop_count  <= '0;
      overflow    <= 1'b0;
    end else begin
      if (capture) begin
        cycle_count <= stamp;
        if (hlt | reg_wr | mem_wr) inst_count <= inst_count + CYCLE_W'(1);
      end
      if (dropNow != 2'd0) begin
        drop_count <= dropSum[DROP_W] ? '1 : dropSum[DROP_W-1:0];
        overflow   <= 1'b1;
      end
    end
  end

  // Head of queue is read straight from storage; fields read zero when empty.
  assign headRec   = fifoMem[rdPtr];
  assign rec_valid = (occupancy != '0);
  assign pop       = rec_valid & rec_ready;
  assign rec_kind  = rec_valid ? headRec.kind  : '0;
  assign rec_addr  = rec_valid ? headRec.addr  : '0;
  assign rec_data  = rec_valid ? headRec.data  : '0;
  assign rec_cycle = rec_valid ? headRec.stamp : '0;

  assign state = stateQ;
  assign done  = ((stateQ == HALTED) || (stateQ == TIMEOUT)) && !rec_valid;

endmodule

// File: tb/tb_trace_capture_unit.sv
// Directed testbench for trace_capture_unit (DEPTH 16, MAX_CYCLES 50).
module tb_trace_capture_unit;

  localparam int DATA_W     = 16;
  localparam int ADDR_W     = 16;
  localparam int REG_W      = 4;
  localparam int DEPTH      = 16;
  localparam int CYCLE_W    = 32;
  localparam int MAX_CYCLES = 50;
  localparam int DROP_W     = 8;

  logic               clk = 1'b0;
  logic               rst;
  logic               start;
  logic               reg_wr;
  logic [REG_W-1:0]   wr_reg;
  logic [DATA_W-1:0]  wr_data;
  logic               mem_rd;
  logic               mem_wr;
  logic [ADDR_W-1:0]  mem_addr;
  logic [DATA_W-1:0]  mem_wdata;
  logic [DATA_W-1:0]  mem_rdata;
  logic               hlt;
  logic               rec_valid;
  logic               rec_ready;
  logic [1:0]         rec_kind;
  logic [ADDR_W-1:0]  rec_addr;
  logic [DATA_W-1:0]  rec_data;
  logic [CYCLE_W-1:0] rec_cycle;
  logic [1:0]         state;
  logic [CYCLE_W-1:0] cycle_count;
  logic [CYCLE_W-1:0] inst_count;
  logic [DROP_W-1:0]  drop_count;
  logic               overflow;
  logic               done;

  int checks = 0;
  int errors = 0;

  trace_capture_unit #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .REG_W(REG_W), .DEPTH(DEPTH),
    .CYCLE_W(CYCLE_W), .MAX_CYCLES(MAX_CYCLES), .DROP_W(DROP_W)
  ) dut (
    .clk(clk), .rst(rst), .start(start),
    .reg_wr(reg_wr), .wr_reg(wr_reg), .wr_data(wr_data),
    .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .hlt(hlt),
    .rec_valid(rec_valid), .rec_ready(rec_ready), .rec_kind(rec_kind),
    .rec_addr(rec_addr), .rec_data(rec_data), .rec_cycle(rec_cycle),
    .state(state), .cycle_count(cycle_count), .inst_count(inst_count),
    .drop_count(drop_count), .overflow(overflow), .done(done)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("FAIL %s observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Advance one clock; outputs are sampled 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    start = 1'b0; reg_wr = 1'b0; wr_reg = '0; wr_data = '0;
    mem_rd = 1'b0; mem_wr = 1'b0; mem_addr = '0; mem_wdata = '0;
    mem_rdata = '0; hlt = 1'b0;
  endtask

  task automatic check_head(input string tag, input logic [1:0] kind,
                            input logic [15:0] addr, input logic [15:0] data,
                            input logic [31:0] cyc);
    check({tag, ".valid"}, 64'(rec_valid), 64'd1);
    check({tag, ".kind"},  64'(rec_kind),  64'(kind));
    check({tag, ".addr"},  64'(rec_addr),  64'(addr));
    check({tag, ".data"},  64'(rec_data),  64'(data));
    check({tag, ".cycle"}, 64'(rec_cycle), 64'(cyc));
  endtask

  initial begin
    // ---- reset state ----
    rst = 1'b1; rec_ready = 1'b0;
    idle_inputs();
    repeat (2) step();
    check("rst.state", 64'(state), 64'd0);
    check("rst.cycle", 64'(cycle_count), 64'd0);
    check("rst.inst",  64'(inst_count), 64'd0);
    check("rst.drop",  64'(drop_count), 64'd0);
    check("rst.ovf",   64'(overflow), 64'd0);
    check("rst.done",  64'(done), 64'd0);
    check("rst.valid", 64'(rec_valid), 64'd0);
    check("rst.fields", {rec_kind, rec_addr, rec_data, rec_cycle[13:0]}, 64'd0);
    rst = 1'b0;

    // ---- IDLE ignores activity ----
    reg_wr = 1'b1; wr_reg = 4'd7; wr_data = 16'h9999; hlt = 1'b1;
    step();
    check("idle.state", 64'(state), 64'd0);
    check("idle.valid", 64'(rec_valid), 64'd0);
    check("idle.inst",  64'(inst_count), 64'd0);
    idle_inputs();

    // ---- start, single REG record at cycle 1 ----
    start = 1'b1; step(); start = 1'b0;
    check("start.state", 64'(state), 64'd1);
    check("start.cycle", 64'(cycle_count), 64'd0);
    reg_wr = 1'b1; wr_reg = 4'd3; wr_data = 16'h1234;
    step();
    idle_inputs();
    check("t1.cycle", 64'(cycle_count), 64'd1);
    check("t1.inst",  64'(inst_count), 64'd1);
    check_head("t1.head", 2'b00, 16'h0003, 16'h1234, 32'd1);
    rec_ready = 1'b1; step();               // cycle 2, pops REG
    check("t1.empty", 64'(rec_valid), 64'd0);

    // ---- REG + STORE same cycle share stamp 3 ----
    rec_ready = 1'b0;
    reg_wr = 1'b1; wr_reg = 4'd1; wr_data = 16'h00AA;
    mem_wr = 1'b1; mem_addr = 16'h0040; mem_wdata = 16'h5555;
    mem_rdata = 16'hDEAD;
    step();
    idle_inputs();
    check("t2.inst", 64'(inst_count), 64'd2);
    check_head("t2.reg", 2'b00, 16'h0001, 16'h00AA, 32'd3);
    rec_ready = 1'b1; step();               // cycle 4, pops REG
    check_head("t2.store", 2'b10, 16'h0040, 16'h5555, 32'd3);
    step();                                 // cycle 5, pops STORE
    check("t2.empty", 64'(rec_valid), 64'd0);
    check("t2.cycle", 64'(cycle_count), 64'd5);

    // ---- 20 loads with no drain: 16 kept, 4 dropped ----
    start = 1'b1; step(); start = 1'b0;
    rec_ready = 1'b0;
    mem_rd = 1'b1; mem_addr = 16'h0010; mem_rdata = 16'hBEEF;
    repeat (20) step();
    check("t3.cycle", 64'(cycle_count), 64'd20);
    check("t3.inst",  64'(inst_count), 64'd0);
    check("t3.drop",  64'(drop_count), 64'd4);
    check("t3.ovf",   64'(overflow), 64'd1);
    check_head("t3.head", 2'b01, 16'h0010, 16'hBEEF, 32'd1);

    // ---- full FIFO: pop + one push in same cycle, no drop ----
    mem_rd = 1'b0;
    reg_wr = 1'b1; wr_reg = 4'd5; wr_data = 16'h0077;
    rec_ready = 1'b1;
    step();                                 // cycle 21
    check("t4.drop", 64'(drop_count), 64'd4);
    check("t4.inst", 64'(inst_count), 64'd1);
    check_head("t4.head", 2'b01, 16'h0010, 16'hBEEF, 32'd2);
    // Still full: one more push without a pop must drop.
    reg_wr = 1'b0; mem_rd = 1'b1; rec_ready = 1'b0;
    step();                                 // cycle 22
    check("t4.full_drop", 64'(drop_count), 64'd5);
    idle_inputs(); rec_ready = 1'b1;
    repeat (15) step();                     // cycles 23..37, pops stamps 2..16
    check_head("t4.last", 2'b00, 16'h0005, 16'h0077, 32'd21);
    step();                                 // cycle 38
    check("t4.empty", 64'(rec_valid), 64'd0);
    check("t4.cycle", 64'(cycle_count), 64'd38);

    // ---- hlt together with reg_wr at cycle 7 ----
    start = 1'b1; step(); start = 1'b0;
    check("t5.ovf_clr", 64'(overflow), 64'd0);
    repeat (6) step();                      // cycles 1..6
    rec_ready = 1'b0;
    hlt = 1'b1; reg_wr = 1'b1; wr_reg = 4'd2; wr_data = 16'hCAFE;
    step();                                 // cycle 7
    check("t5.state", 64'(state), 64'd2);
    check("t5.cycle", 64'(cycle_count), 64'd7);
    check("t5.inst",  64'(inst_count), 64'd1);
    check("t5.done0", 64'(done), 64'd0);
    hlt = 1'b0; wr_reg = 4'd9; mem_wr = 1'b1; mem_addr = 16'h0100;
    repeat (2) step();                      // halted: no capture
    idle_inputs();
    check("t5.frozen", 64'(cycle_count), 64'd7);
    check("t5.inst_frozen", 64'(inst_count), 64'd1);
    check_head("t5.head", 2'b00, 16'h0002, 16'hCAFE, 32'd7);
    rec_ready = 1'b1; step();
    check("t5.valid", 64'(rec_valid), 64'd0);
    check("t5.done1", 64'(done), 64'd1);

    // ---- watchdog: 50 cycles then TIMEOUT ----
    start = 1'b1; step(); start = 1'b0;
    repeat (MAX_CYCLES) step();
    check("t6.run", 64'(state), 64'd1);
    check("t6.cycle50", 64'(cycle_count), 64'd50);
    reg_wr = 1'b1; wr_reg = 4'd6; hlt = 1'b1;
    step();
    idle_inputs();
    check("t6.state", 64'(state), 64'd3);
    check("t6.cycle", 64'(cycle_count), 64'd50);
    check("t6.inst",  64'(inst_count), 64'd0);
    check("t6.valid", 64'(rec_valid), 64'd0);
    check("t6.done",  64'(done), 64'd1);

    // ---- start overrides capture, then async reset mid-RUN ----
    start = 1'b1; step(); start = 1'b0;
    rec_ready = 1'b0;
    reg_wr = 1'b1; wr_reg = 4'd4; wr_data = 16'h1111;
    repeat (2) step();
    check("t7.inst2", 64'(inst_count), 64'd2);
    start = 1'b1; step(); start = 1'b0;     // reg_wr still high, ignored
    check("t7.restart_cycle", 64'(cycle_count), 64'd0);
    check("t7.restart_inst",  64'(inst_count), 64'd0);
    check("t7.restart_valid", 64'(rec_valid), 64'd0);
    step();                                 // cycle 1 captures
    check_head("t7.head", 2'b00, 16'h0004, 16'h1111, 32'd1);
    #2 rst = 1'b1;
    #1;
    check("t7.rst_state", 64'(state), 64'd0);
    check("t7.rst_cycle", 64'(cycle_count), 64'd0);
    check("t7.rst_inst",  64'(inst_count), 64'd0);
    check("t7.rst_valid", 64'(rec_valid), 64'd0);
    check("t7.rst_fields", {rec_kind, rec_addr, rec_data, rec_cycle[13:0]}, 64'd0);
    idle_inputs();
    step();
    rst = 1'b0;
    step();
    check("t7.idle", 64'(state), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
